// File: rtl/truth_table_sweeper.sv
// Truth-table sweeper: walks A..D through 0000..1111, samples F per vector and
// compares the captured table against an expected one. Optional macro: TT_SWEEP_STOP_ON_FAIL_EN.
module truth_table_sweeper #(
    parameter int HOLD_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] expected,
    input  logic        f_in,
    output logic        A,
    output logic        B,
    output logic        C,
    output logic        D,
    output logic        busy,
    output logic        done,
    output logic [15:0] truth,
    output logic        mismatch,
    output logic [4:0]  mismatch_cnt,
    output logic [3:0]  first_fail
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

    state_t      r_state;
    logic [3:0]  r_vec;
    logic [7:0]  r_hold;
    logic [15:0] r_truth;
    logic        r_mis;
    logic [4:0]  r_cnt;
    logic [3:0]  r_first;
    logic        r_busy;
    logic        r_done;
    logic [3:0]  r_stim;

    state_t      w_state_nxt;
    logic [3:0]  w_vec_nxt;
    logic [7:0]  w_hold_nxt;
    logic [15:0] w_truth_nxt;
    logic        w_mis_nxt;
    logic [4:0]  w_cnt_nxt;
    logic [3:0]  w_first_nxt;
    logic        w_sample;
    logic        w_fail;
    logic        w_stop;

    assign w_sample = (r_state == S_RUN) && (r_hold == HOLD_LAST);
    assign w_fail   = w_sample && (f_in != expected[r_vec]);

`ifdef TT_SWEEP_STOP_ON_FAIL_EN
    assign w_stop = (r_vec == 4'd15) || w_fail;
`else
    assign w_stop = (r_vec == 4'd15);
`endif

    // Next-state and result-update logic.
    always_comb begin
        w_state_nxt = r_state;
        w_vec_nxt   = r_vec;
        w_hold_nxt  = r_hold;
        w_truth_nxt = r_truth;
        w_mis_nxt   = r_mis;
        w_cnt_nxt   = r_cnt;
        w_first_nxt = r_first;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_RUN;
                    w_vec_nxt   = 4'd0;
                    w_hold_nxt  = 8'd0;
                    w_truth_nxt = 16'd0;
                    w_mis_nxt   = 1'b0;
                    w_cnt_nxt   = 5'd0;
                    w_first_nxt = 4'd0;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_RUN: begin
                if (w_sample) begin
                    w_truth_nxt[r_vec] = f_in;
                    if (w_fail) begin
                        w_mis_nxt = 1'b1;
                        w_cnt_nxt = r_cnt + 5'd1;
                        if (!r_mis) begin
                            w_first_nxt = r_vec;
                        end else begin
                            w_first_nxt = r_first;
                        end
                    end else begin
                        w_mis_nxt = r_mis;
                    end
                    if (w_stop) begin
                        w_state_nxt = S_FINISH;
                    end else begin
                        w_vec_nxt  = r_vec + 4'd1;
                        w_hold_nxt = 8'd0;
                    end
                end else begin
                    w_hold_nxt = r_hold + 8'd1;
                end
            end
            S_FINISH: w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // State, results and registered outputs; outputs are computed from next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_vec   <= 4'd0;
            r_hold  <= 8'd0;
            r_truth <= 16'd0;
            r_mis   <= 1'b0;
            r_cnt   <= 5'd0;
            r_first <= 4'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_stim  <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_vec   <= w_vec_nxt;
            r_hold  <= w_hold_nxt;
            r_truth <= w_truth_nxt;
            r_mis   <= w_mis_nxt;
            r_cnt   <= w_cnt_nxt;
            r_first <= w_first_nxt;
            r_busy  <= (w_state_nxt == S_RUN);
            r_done  <= (w_state_nxt == S_FINISH);
            r_stim  <= (w_state_nxt == S_RUN) ? w_vec_nxt : 4'd0;
        end
    end

    assign {A, B, C, D}  = r_stim;
    assign busy          = r_busy;
    assign done          = r_done;
    assign truth         = r_truth;
    assign mismatch      = r_mis;
    assign mismatch_cnt  = r_cnt;
    assign first_fail    = r_first;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper: a HOLD=2 instance with F wired to a
// selectable function of A..D, and a HOLD=1 instance with F tied low.
module tb_truth_table_sweeper;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, start2;
    logic [15:0] expected, expected2;
    logic [1:0]  f_sel;
    logic        f_in, f_in2;
    logic        A, B, C, D, busy, done, mismatch;
    logic [15:0] truth;
    logic [4:0]  mismatch_cnt;
    logic [3:0]  first_fail;
    logic        A2, B2, C2, D2, busy2, done2, mismatch2;
    logic [15:0] truth2;
    logic [4:0]  mismatch_cnt2;
    logic [3:0]  first_fail2;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    assign f_in  = (f_sel == 2'd0) ? D : (f_sel == 2'd1) ? ((A & B) | (C & ~D)) : 1'b0;
    assign f_in2 = 1'b0;

    truth_table_sweeper #(.HOLD_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .start(start), .expected(expected), .f_in(f_in),
        .A(A), .B(B), .C(C), .D(D), .busy(busy), .done(done), .truth(truth),
        .mismatch(mismatch), .mismatch_cnt(mismatch_cnt), .first_fail(first_fail)
    );

    truth_table_sweeper #(.HOLD_CYCLES(1)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .expected(expected2), .f_in(f_in2),
        .A(A2), .B(B2), .C(C2), .D(D2), .busy(busy2), .done(done2), .truth(truth2),
        .mismatch(mismatch2), .mismatch_cnt(mismatch_cnt2), .first_fail(first_fail2)
    );

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; start2 = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0; start = 1'b0; start2 = 1'b0;
        checks++;
        if ({A, B, C, D, busy, done, mismatch} !== 7'd0) $display("FAIL reset_ctrl got %b exp 0", {A, B, C, D, busy, done, mismatch});
        else passed++;
        checks++;
        if ({truth, mismatch_cnt, first_fail} !== 25'd0) $display("FAIL reset_results got %h exp 0", {truth, mismatch_cnt, first_fail});
        else passed++;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) $display("FAIL reset_start_ignored busy got %b exp 0", busy);
        else passed++;
    endtask

    task automatic test_sweep_pass();
        int bad = 0;
        int busy_n = 0;
        f_sel = 2'd0; expected = 16'hAAAA;
        start = 1'b1; @(negedge clk); start = 1'b0;
        for (int c = 1; c <= 32; c++) begin
            if ({A, B, C, D} !== 4'((c - 1) / 2) || done !== 1'b0) begin
                if (bad == 0) $display("FAIL pass_stim cycle %0d got %b exp %b", c, {A, B, C, D}, 4'((c - 1) / 2));
                bad++;
            end
            if (busy === 1'b1) busy_n++;
            @(negedge clk);
        end
        checks++;
        if (bad !== 0) $display("FAIL pass_stim_seq bad cycles got %0d exp 0", bad);
        else passed++;
        checks++;
        if (busy_n !== 32) $display("FAIL pass_busy_len got %0d exp 32", busy_n);
        else passed++;
        checks++;
        if ({done, busy, A, B, C, D} !== 6'b100000) $display("FAIL pass_done33 got %b exp 100000", {done, busy, A, B, C, D});
        else passed++;
        checks++;
        if ({truth, mismatch, mismatch_cnt} !== {16'hAAAA, 1'b0, 5'd0}) $display("FAIL pass_results got %h/%b/%0d exp aaaa/0/0", truth, mismatch, mismatch_cnt);
        else passed++;
        @(negedge clk);
        checks++;
        if (done !== 1'b0) $display("FAIL pass_done_pulse got %b exp 0", done);
        else passed++;
    endtask

    task automatic test_sweep_fail();
        f_sel = 2'd0; expected = 16'hAAAB;
        start = 1'b1; @(negedge clk); start = 1'b0;
        repeat (32) @(negedge clk);
        checks++;
        if ({done, truth, mismatch} !== {1'b1, 16'hAAAA, 1'b1}) $display("FAIL fail_results got %b/%h/%b exp 1/aaaa/1", done, truth, mismatch);
        else passed++;
        checks++;
        if ({mismatch_cnt, first_fail} !== {5'd1, 4'd0}) $display("FAIL fail_count got %0d/%0d exp 1/0", mismatch_cnt, first_fail);
        else passed++;
        repeat (3) @(negedge clk);
        checks++;
        if ({truth, mismatch, mismatch_cnt} !== {16'hAAAA, 1'b1, 5'd1}) $display("FAIL fail_hold got %h/%b/%0d exp aaaa/1/1", truth, mismatch, mismatch_cnt);
        else passed++;
    endtask

    task automatic test_restart_ignored();
        int dones = 0;
        int done_at = 0;
        f_sel = 2'd1; expected = 16'hF444;
        start = 1'b1; @(negedge clk); start = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            start = (c == 15) ? 1'b1 : 1'b0;
            if (done === 1'b1) begin
                dones++;
                done_at = c;
            end
            @(negedge clk);
        end
        start = 1'b0;
        checks++;
        if (dones !== 1 || done_at !== 33) $display("FAIL restart_done got %0d pulses at %0d exp 1 at 33", dones, done_at);
        else passed++;
        checks++;
        if ({truth, mismatch, mismatch_cnt} !== {16'hF444, 1'b0, 5'd0}) $display("FAIL restart_results got %h/%b/%0d exp f444/0/0", truth, mismatch, mismatch_cnt);
        else passed++;
    endtask

    task automatic test_mid_reset();
        int dones = 0;
        f_sel = 2'd0; expected = 16'hAAAA;
        start = 1'b1; @(negedge clk); start = 1'b0;
        repeat (10) @(negedge clk);
        checks++;
        if ({A, B, C, D} !== 4'd5) $display("FAIL midrst_vec5 got %b exp 0101", {A, B, C, D});
        else passed++;
        rst = 1'b1; @(negedge clk); rst = 1'b0;
        checks++;
        if ({A, B, C, D, busy, done, truth} !== 22'd0) $display("FAIL midrst_clear got %h exp 0", {A, B, C, D, busy, done, truth});
        else passed++;
        for (int c = 0; c < 30; c++) begin
            if (done === 1'b1 || busy === 1'b1) dones++;
            @(negedge clk);
        end
        checks++;
        if (dones !== 0) $display("FAIL midrst_quiet got %0d active cycles exp 0", dones);
        else passed++;
        start = 1'b1; @(negedge clk); start = 1'b0;
        repeat (32) @(negedge clk);
        checks++;
        if ({done, truth, mismatch, mismatch_cnt} !== {1'b1, 16'hAAAA, 1'b0, 5'd0}) $display("FAIL midrst_resweep got %b/%h/%b/%0d exp 1/aaaa/0/0", done, truth, mismatch, mismatch_cnt);
        else passed++;
        @(negedge clk);
    endtask

    task automatic test_hold1();
        int busy_n = 0;
        int done_at = 0;
        int exp_busy, exp_done_at, exp_cnt;
`ifdef TT_SWEEP_STOP_ON_FAIL_EN
        exp_busy = 1; exp_done_at = 2; exp_cnt = 1;
`else
        exp_busy = 16; exp_done_at = 17; exp_cnt = 16;
`endif
        expected2 = 16'hFFFF;
        start2 = 1'b1; @(negedge clk); start2 = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            if (busy2 === 1'b1) busy_n++;
            if (done2 === 1'b1) done_at = c;
            @(negedge clk);
        end
        checks++;
        if (busy_n !== exp_busy) $display("FAIL hold1_busy got %0d exp %0d", busy_n, exp_busy);
        else passed++;
        checks++;
        if (done_at !== exp_done_at) $display("FAIL hold1_done_cycle got %0d exp %0d", done_at, exp_done_at);
        else passed++;
        checks++;
        if ({mismatch2, 32'(mismatch_cnt2), first_fail2, truth2} !== {1'b1, 32'(exp_cnt), 4'd0, 16'd0}) $display("FAIL hold1_results got %b/%0d/%0d/%h exp 1/%0d/0/0000", mismatch2, mismatch_cnt2, first_fail2, truth2, exp_cnt);
        else passed++;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; start2 = 1'b0;
        expected = 16'd0; expected2 = 16'd0; f_sel = 2'd0;
        @(negedge clk);
        test_reset();
        test_sweep_pass();
        test_sweep_fail();
        test_restart_ignored();
        test_mid_reset();
        test_hold1();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
